fnd_scan_driver: RTL

- Upstream stage of the BCD-to-FND digit decoder.
- Accepts a 14-bit binary result from the arithmetic path and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Holds the converted digits in a display register and time-multiplexes them onto a 2-bit digit select, a 4-bit digit value and a digit enable.
- Those three outputs drive the decoder's digit-select, value and enable inputs directly.

---
 rtl/fnd_scan_driver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fnd_scan_driver.sv
// Binary-to-BCD front end for the FND digit decoder: an iterative double-dabble
// conversion feeds a display register, which is time-multiplexed one digit at a
// time onto the select/value/enable outputs.
module fnd_scan_driver #(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_bcdDigit,
  output logic        o_en
);

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  localparam int unsigned     PresW    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(SCAN_DIV - 1);
  localparam logic [13:0]     MaxValue = 14'd9999;

  state_e      state_q, state_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  iter_q, iter_d;
  logic        pend_ovf_q, pend_ovf_d;
  logic [15:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic [15:0] acc_adj;
  logic [15:0] acc_shift;

  logic [PresW-1:0] pres_q;
  logic [1:0]       sel_q;

  // Conversion and display state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      pend_ovf_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      iter_q     <= iter_d;
      pend_ovf_q <= pend_ovf_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  // Double-dabble step and FSM next state; display only updates on the final step.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    iter_d     = iter_q;
    pend_ovf_d = pend_ovf_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    acc_adj    = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[14:0], shift_q[13]};

    unique case (state_q)
      StIdle: begin
        if (i_load) begin
          shift_d    = (i_value > MaxValue) ? MaxValue : i_value;
          acc_d      = '0;
          iter_d     = '0;
          pend_ovf_d = (i_value > MaxValue);
          state_d    = StConvert;
        end
      end
      StConvert: begin
        acc_d   = acc_shift;
        shift_d = {shift_q[12:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          disp_d  = acc_shift;
          ovf_d   = pend_ovf_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running scan prescaler; advances the digit slot on terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pres_q <= '0;
      sel_q  <= 2'd0;
    end else if (pres_q == PresLast) begin
      pres_q <= '0;
      sel_q  <= sel_q + 2'd1;
    end else begin
      pres_q <= pres_q + 1'b1;
    end
  end

  // Digit value mux and leading-zero blanking for the active slot.
  always_comb begin
    o_bcdDigit = disp_q[3:0];
    o_en       = 1'b1;
    unique case (sel_q)
      2'd0: begin
        o_bcdDigit = disp_q[3:0];
        o_en       = 1'b1;
      end
      2'd1: begin
        o_bcdDigit = disp_q[7:4];
        o_en       = !BLANK_LEADING || (|disp_q[15:4]);
      end
      2'd2: begin
        o_bcdDigit = disp_q[11:8];
        o_en       = !BLANK_LEADING || (|disp_q[15:8]);
      end
      2'd3: begin
        o_bcdDigit = disp_q[15:12];
        o_en       = !BLANK_LEADING || (|disp_q[15:12]);
      end
      default: begin
        o_bcdDigit = disp_q[3:0];
        o_en       = 1'b1;
      end
    endcase
  end

  assign o_busy        = (state_q == StConvert);
  assign o_overflow    = ovf_q;
  assign o_digitSelect = sel_q;

endmodule
